// File: rtl/nmt_ctx_pkg.sv
// Shared types and defaults for the near-memory threading core context-switch logic.
package nmt_ctx_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned NREGS_DEF    = 8;
  localparam int unsigned NTHREADS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    RESTORE,
    DONE
  } ctx_state_e;

  typedef logic [$clog2(NTHREADS_DEF)-1:0] tid_t;
  typedef logic [$clog2(NREGS_DEF)-1:0]    reg_idx_t;

endpackage

// File: rtl/ctx_switch_seq_ctx_store.sv
// Per-thread context store: NTHREADS x NREGS words, one synchronous write port,
// one combinational read port, asynchronous clear of every word.
module ctx_store
  import nmt_ctx_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NTHREADS = NTHREADS_DEF,
  parameter int unsigned TID_W    = $clog2(NTHREADS),
  parameter int unsigned IDX_W    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [TID_W-1:0]  wr_tid,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [TID_W-1:0]  rd_tid,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [NTHREADS][NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned t = 0; t < NTHREADS; t++) begin
        for (int unsigned i = 0; i < NREGS; i++) begin
          mem[t][i] <= '0;
        end
      end
    end else if (we) begin
      mem[wr_tid][wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_tid][rd_idx];

endmodule

// File: rtl/ctx_switch_seq.sv
// Thread context-switch sequencer: saves the outgoing thread's registers into the
// context store, then restores the incoming thread's registers into the register file.
module ctx_switch_seq
  import nmt_ctx_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NTHREADS = NTHREADS_DEF,
  parameter int unsigned TID_W    = $clog2(NTHREADS),
  parameter int unsigned IDX_W    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw_req_valid,
  output logic              sw_req_ready,
  input  logic [TID_W-1:0]  sw_old_tid,
  input  logic [TID_W-1:0]  sw_new_tid,
  output logic [IDX_W-1:0]  rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [IDX_W-1:0]  rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              busy,
  output logic              done,
  output logic [TID_W-1:0]  cur_tid
);

  localparam int unsigned K_W = $clog2(NREGS + 1);
  localparam logic [K_W-1:0] K_SAVE_LAST    = K_W'(NREGS);
  localparam logic [K_W-1:0] K_RESTORE_LAST = K_W'(NREGS - 1);

  ctx_state_e        state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [TID_W-1:0]  old_q, new_q, cur_q;

  logic              st_we;
  logic [IDX_W-1:0]  st_wr_idx;
  logic [IDX_W-1:0]  st_rd_idx;
  logic [DATA_W-1:0] st_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      old_q   <= '0;
      new_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (state_q == IDLE && sw_req_valid) begin
        old_q <= sw_old_tid;
        new_q <= sw_new_tid;
      end
      if (state_q == DONE) begin
        cur_q <= new_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        k_d = '0;
        if (sw_req_valid) begin
          state_d = (sw_old_tid == sw_new_tid) ? DONE : SAVE;
        end
      end
      SAVE: begin
        if (k_q == K_SAVE_LAST) begin
          state_d = RESTORE;
          k_d     = '0;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      RESTORE: begin
        if (k_q == K_RESTORE_LAST) begin
          state_d = DONE;
          k_d     = '0;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        k_d     = '0;
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  // Read data lags the address by one cycle, so SAVE step k stores the word fetched at k-1.
  always_comb begin
    sw_req_ready = (state_q == IDLE);
    busy         = (state_q != IDLE);
    done         = (state_q == DONE);
    cur_tid      = cur_q;
    rf_rd_addr   = '0;
    rf_wr_en     = 1'b0;
    rf_wr_addr   = '0;
    rf_wr_data   = '0;
    st_we        = 1'b0;
    st_wr_idx    = IDX_W'(k_q - K_W'(1));
    st_rd_idx    = IDX_W'(k_q);
    if (state_q == SAVE) begin
      if (k_q != K_SAVE_LAST) begin
        rf_rd_addr = IDX_W'(k_q);
      end
      st_we = (k_q != '0);
    end
    if (state_q == RESTORE) begin
      rf_wr_en   = 1'b1;
      rf_wr_addr = IDX_W'(k_q);
      rf_wr_data = st_rd_data;
    end
  end

  ctx_store #(
    .DATA_W   (DATA_W),
    .NREGS    (NREGS),
    .NTHREADS (NTHREADS),
    .TID_W    (TID_W),
    .IDX_W    (IDX_W)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (st_we),
    .wr_tid  (old_q),
    .wr_idx  (st_wr_idx),
    .wr_data (rf_rd_data),
    .rd_tid  (new_q),
    .rd_idx  (st_rd_idx),
    .rd_data (st_rd_data)
  );

endmodule

// File: tb/tb_ctx_switch_seq.sv
// Self-checking bench for ctx_switch_seq: directed scenarios plus randomized switches
// checked against a per-slot context model and a cycle schedule derived from NREGS.
module tb_ctx_switch_seq;

  localparam int DW = 32;
  localparam int NR = 8;
  localparam int NT = 4;
  localparam int TW = 2;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sw_req_valid = 1'b0;
  logic          sw_req_ready;
  logic [TW-1:0] sw_old_tid = '0;
  logic [TW-1:0] sw_new_tid = '0;
  logic [IW-1:0] rf_rd_addr;
  logic [DW-1:0] rf_rd_data;
  logic          rf_wr_en;
  logic [IW-1:0] rf_wr_addr;
  logic [DW-1:0] rf_wr_data;
  logic          busy;
  logic          done;
  logic [TW-1:0] cur_tid;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rf [NR];
  logic [DW-1:0] ctx_m [NT][NR];
  int            cur_m = 0;

  always #5 clk = ~clk;

  ctx_switch_seq #(.DATA_W(DW), .NREGS(NR), .NTHREADS(NT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_req_valid (sw_req_valid),
    .sw_req_ready (sw_req_ready),
    .sw_old_tid   (sw_old_tid),
    .sw_new_tid   (sw_new_tid),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .busy         (busy),
    .done         (done),
    .cur_tid      (cur_tid)
  );

  // Register file environment: registered read, synchronous write.
  always @(posedge clk) begin
    rf_rd_data <= rf[rf_rd_addr];
    if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_rf(input logic [DW-1:0] base, input bit rnd);
    for (int i = 0; i < NR; i++) rf[i] = rnd ? DW'($urandom) : base + DW'(i);
  endtask

  task automatic clear_model();
    for (int t = 0; t < NT; t++)
      for (int i = 0; i < NR; i++) ctx_m[t][i] = '0;
    cur_m = 0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after done.
  task automatic do_switch(input int o, input int n, input bit noise,
                           input bit chain, input int no, input int nn);
    logic [DW-1:0] snap [NR];
    logic [DW-1:0] exp_w [NR];
    int lat;
    bit wr_exp;
    sw_old_tid   = TW'(o);
    sw_new_tid   = TW'(n);
    sw_req_valid = 1'b1;
    chk("ready_idle", 64'(sw_req_ready), 64'd1);
    @(posedge clk);
    for (int i = 0; i < NR; i++) begin
      snap[i]  = rf[i];
      exp_w[i] = ctx_m[n][i];
    end
    if (o != n) for (int i = 0; i < NR; i++) ctx_m[o][i] = snap[i];
    lat = (o == n) ? 1 : 2 * NR + 2;
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(negedge clk);
      if (cyc == lat) begin
        sw_req_valid = chain;
        if (chain) begin
          sw_old_tid = TW'(no);
          sw_new_tid = TW'(nn);
        end
      end else if (noise) begin
        sw_req_valid = 1'($urandom);
        sw_old_tid   = TW'($urandom);
        sw_new_tid   = TW'($urandom);
      end else begin
        sw_req_valid = 1'b0;
      end
      chk("busy", 64'(busy), 64'd1);
      chk("ready_busy", 64'(sw_req_ready), 64'd0);
      chk("done", 64'(done), 64'(cyc == lat));
      wr_exp = (o != n) && (cyc >= NR + 2) && (cyc <= 2 * NR + 1);
      chk("wr_en", 64'(rf_wr_en), 64'(wr_exp));
      if (wr_exp) begin
        chk("wr_addr", 64'(rf_wr_addr), 64'(cyc - NR - 2));
        chk("wr_data", 64'(rf_wr_data), 64'(exp_w[cyc - NR - 2]));
      end
      if (o != n && cyc <= NR) chk("rd_addr", 64'(rf_rd_addr), 64'(cyc - 1));
    end
    @(negedge clk);
    cur_m = n;
    chk("ready_after", 64'(sw_req_ready), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);
    chk("done_after", 64'(done), 64'd0);
    chk("cur_tid", 64'(cur_tid), 64'(cur_m));
    if (o != n) for (int i = 0; i < NR; i++) chk("rf_restored", 64'(rf[i]), 64'(exp_w[i]));
  endtask

  initial begin
    int o, n, no, nn;
    bit chain;
    clear_model();
    load_rf(32'hA000_0000, 1'b0);
    #12;
    chk("rst_ready", 64'(sw_req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wr_en", 64'(rf_wr_en), 64'd0);
    chk("rst_cur_tid", 64'(cur_tid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: slot 1 empty, so zeros are restored
    do_switch(0, 1, 1'b0, 1'b0, 0, 0);
    chk("t1_rf0_zero", 64'(rf[0]), 64'd0);

    // 2: slot 0 holds the A pattern
    load_rf(32'hB000_0000, 1'b0);
    do_switch(1, 0, 1'b0, 1'b0, 0, 0);
    chk("t2_rf7", 64'(rf[7]), 64'hA000_0007);

    // 3: same tid, done on cycle 1 with no writes
    do_switch(2, 2, 1'b0, 1'b0, 0, 0);

    // 4: back-to-back with valid held through done
    do_switch(0, 3, 1'b0, 1'b1, 3, 1);
    do_switch(3, 1, 1'b0, 1'b0, 0, 0);

    // 5: reset in the middle of SAVE at k=3
    load_rf(32'hC000_0000, 1'b0);
    sw_old_tid   = 2'd3;
    sw_new_tid   = 2'd0;
    sw_req_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      sw_req_valid = 1'b0;
    end
    chk("t5_rd_addr_k3", 64'(rf_rd_addr), 64'd3);
    rst_n = 1'b0;
    #1;
    clear_model();
    chk("t5_ready", 64'(sw_req_ready), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_wr_en", 64'(rf_wr_en), 64'd0);
    chk("t5_rd_addr", 64'(rf_rd_addr), 64'd0);
    chk("t5_wr_addr", 64'(rf_wr_addr), 64'd0);
    chk("t5_wr_data", 64'(rf_wr_data), 64'd0);
    chk("t5_cur_tid", 64'(cur_tid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_switch(1, 3, 1'b0, 1'b0, 0, 0);
    chk("t5_rf3_zero", 64'(rf[3]), 64'd0);

    // 6: input noise while busy
    load_rf(0, 1'b1);
    do_switch(2, 1, 1'b1, 1'b0, 0, 0);

    // randomized switches
    no = $urandom_range(NT - 1);
    nn = $urandom_range(NT - 1);
    for (int it = 0; it < 30; it++) begin
      o = no;
      n = nn;
      no = $urandom_range(NT - 1);
      nn = ($urandom_range(3) == 0) ? no : int'($urandom_range(NT - 1));
      chain = 1'($urandom);
      if ($urandom_range(2) == 0) load_rf(0, 1'b1);
      do_switch(o, n, 1'($urandom), chain, no, nn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
